// File: rtl/fp_align_pkg.sv
// Shared encodings for the FP add/sub exponent alignment stage:
// controller state encoding and shifter direction constants.
package fp_align_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_LOAD    = 2'd2,
      ST_DONE    = 2'd3
   } align_state_t;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/exp_diff_sat.sv
// Combinational operand compare for alignment: picks the larger operand and
// produces the right-shift distance for the smaller one, saturated at SW.
module exp_diff_sat #(
   parameter int SW = 26,
   parameter int EW = 8
) (
   input  logic [EW-1:0] exp_x,
   input  logic [EW-1:0] exp_y,
   input  logic [SW-1:0] mant_x,
   input  logic [SW-1:0] mant_y,
   output logic          swap,
   output logic [EW-1:0] shamt
);

   localparam logic [EW-1:0] SW_SAT = EW'(SW);

   logic [EW:0]   diff;
   logic [EW-1:0] mag;

   always_comb begin
      diff = {1'b0, exp_x} - {1'b0, exp_y};
      // |diff| never exceeds 2^EW-1, so the low EW bits of the negation suffice.
      mag  = diff[EW] ? EW'(-diff) : diff[EW-1:0];
      // Shifting by SW or more already flushes the whole mantissa.
      shamt = (mag > SW_SAT) ? SW_SAT : mag;
      swap  = (exp_y > exp_x) || ((exp_y == exp_x) && (mant_y > mant_x));
   end

endmodule

// File: rtl/exp_align_ctrl.sv
// Alignment controller in front of the mantissa barrel shifter: captures two
// operands, orders them, strobes the shifter once and holds results until ack.
module exp_align_ctrl
   import fp_align_pkg::*;
#(
   parameter int SW = 26,
   parameter int EW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [EW-1:0] exp_x_i,
   input  logic [EW-1:0] exp_y_i,
   input  logic [SW-1:0] mant_x_i,
   input  logic [SW-1:0] mant_y_i,
   input  logic          ack_i,
   output logic          ready_o,
   output logic [EW-1:0] Shift_Value_o,
   output logic [SW-1:0] Shift_Data_o,
   output logic          FSM_left_right_o,
   output logic          ctrl_a_o,
   output logic [SW-1:0] mant_large_o,
   output logic [EW-1:0] exp_common_o,
   output logic          swap_o,
   output logic          done_o
);

   align_state_t state_reg, state_next;

   logic [EW-1:0] exp_x_reg, exp_y_reg;
   logic [SW-1:0] mant_x_reg, mant_y_reg;

   logic [EW-1:0] shift_value_reg, exp_common_reg;
   logic [SW-1:0] shift_data_reg, mant_large_reg;
   logic          swap_reg;

   logic          cmp_swap;
   logic [EW-1:0] cmp_shamt;

   exp_diff_sat #(
      .SW (SW),
      .EW (EW)
   ) u_exp_diff_sat (
      .exp_x  (exp_x_reg),
      .exp_y  (exp_y_reg),
      .mant_x (mant_x_reg),
      .mant_y (mant_y_reg),
      .swap   (cmp_swap),
      .shamt  (cmp_shamt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= ST_IDLE;
         exp_x_reg       <= '0;
         exp_y_reg       <= '0;
         mant_x_reg      <= '0;
         mant_y_reg      <= '0;
         shift_value_reg <= '0;
         shift_data_reg  <= '0;
         mant_large_reg  <= '0;
         exp_common_reg  <= '0;
         swap_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if ((state_reg == ST_IDLE) && start_i) begin
            exp_x_reg  <= exp_x_i;
            exp_y_reg  <= exp_y_i;
            mant_x_reg <= mant_x_i;
            mant_y_reg <= mant_y_i;
         end
         // Result registers load on leaving COMPARE so they are valid in LOAD
         // and then hold through DONE and the following IDLE.
         if (state_reg == ST_COMPARE) begin
            shift_value_reg <= cmp_shamt;
            swap_reg        <= cmp_swap;
            shift_data_reg  <= cmp_swap ? mant_x_reg : mant_y_reg;
            mant_large_reg  <= cmp_swap ? mant_y_reg : mant_x_reg;
            exp_common_reg  <= cmp_swap ? exp_y_reg  : exp_x_reg;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ready_o    = 1'b0;
      ctrl_a_o   = 1'b0;
      done_o     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (start_i) state_next = ST_COMPARE;
         end
         ST_COMPARE: state_next = ST_LOAD;
         ST_LOAD: begin
            ctrl_a_o   = 1'b1;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            done_o = 1'b1;
            if (ack_i) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign FSM_left_right_o = DIR_RIGHT;
   assign Shift_Value_o    = shift_value_reg;
   assign Shift_Data_o     = shift_data_reg;
   assign mant_large_o     = mant_large_reg;
   assign exp_common_o     = exp_common_reg;
   assign swap_o           = swap_reg;

endmodule

// File: doc/exp_align_ctrl.md
Name: exp_align_ctrl

Overview:
- Control and data-prep stage directly upstream of the mantissa barrel shifter in the FP add/sub datapath.
- Accepts two operands as exponent/mantissa pairs, then compares exponents and picks the larger operand.
- Computes the saturated alignment shift and presents the smaller mantissa, shift amount, direction and a one-cycle load strobe to the shifter.
- Holds the larger mantissa and common exponent for the downstream adder until acknowledged.

Parameters:
- SW, 26: mantissa width incl. implicit, guard and round bits (55 for double). Must satisfy SW < 2^EW.
- EW, 8: exponent width (11 for double).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start_i  in  1  operand valid; accepted only when ready_o=1.
- exp_x_i  in  EW  exponent of operand X.
- exp_y_i  in  EW  exponent of operand Y.
- mant_x_i  in  SW  mantissa of operand X.
- mant_y_i  in  SW  mantissa of operand Y.
- ack_i  in  1  downstream consumed result; honoured only in DONE.
- ready_o  out  1  high in IDLE.
- Shift_Value_o  out  EW  shift amount to the shifter.
- Shift_Data_o  out  SW  smaller operand's mantissa to the shifter.
- FSM_left_right_o  out  1  shift direction: 1=left, 0=right. This block always drives 0.
- ctrl_a_o  out  1  shifter output-register load strobe.
- mant_large_o  out  SW  larger operand's mantissa.
- exp_common_o  out  EW  larger exponent.
- swap_o  out  1  1 when Y was selected as the larger operand.
- done_o  out  1  results valid; shifter output valid from this cycle.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 except ready_o=1. Operand registers cleared. Reset mid-operation aborts the operation; no ctrl_a_o pulse is emitted.
- FSM states: IDLE, COMPARE, LOAD, DONE (one-hot or binary, from the package).
- IDLE: ready_o=1.
  - start_i=1 captures exp_x/exp_y/mant_x/mant_y into registers and moves to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE (exactly 1 cycle):
  - diff = {0,exp_x} - {0,exp_y}, computed on EW+1 bits.
  - swap = 1 if exp_y > exp_x, or if exps are equal and mant_y > mant_x. Otherwise swap = 0.
  - mag = |diff|, EW bits. shamt = (mag > SW) ? SW : mag.
  - Register swap and shamt; go to LOAD.
- LOAD (exactly 1 cycle):
  - ctrl_a_o=1.
  - Shift_Value_o=shamt, Shift_Data_o=smaller mantissa, FSM_left_right_o=0.
  - mant_large_o, exp_common_o and swap_o are driven from this cycle.
  - Go to DONE.
- DONE: done_o=1. All data outputs held stable; ctrl_a_o=0.
  - ack_i=1 returns to IDLE.
  - Otherwise stay in DONE.
- Latency: start accepted at edge 0 → ctrl_a_o high in cycle 2 → done_o high in cycle 3. The shifter's N_mant_o is valid in the same cycle done_o rises.
- Throughput: one operation per 4 cycles minimum; no pipelining of a second operation.
- Ignored inputs:
  - start_i outside IDLE, including start_i together with ack_i in DONE. ack wins; the next start must arrive in IDLE.
  - ack_i outside DONE.
- Data outputs in IDLE retain their last values. Only done_o, ctrl_a_o and ready_o are qualifying signals.
- Boundaries:
  - mag=0 → shamt=0.
  - mag=SW → shamt=SW, no clamp needed.
  - mag=2^EW-1 → shamt=SW.
  - Equal exponents and equal mantissas → swap=0.

Decomposition:
- Package fp_align_pkg holds:
  - FSM state encodings.
  - FSM_left_right encoding constants (DIR_LEFT=1, DIR_RIGHT=0).
- One sub-module: exp_diff_sat. It is combinational: exponent/mantissa compare, EW+1-bit subtract, magnitude, and clamp to SW. It takes exps and mants and outputs swap and shamt.
- FSM and registers live in exp_align_ctrl.

Test Plan (SW=26, EW=8):
- exp_x=0x85, exp_y=0x80, mant_x=0x2000000, mant_y=0x3000000, start → cycle 2:
  - ctrl_a_o=1, Shift_Value_o=5, Shift_Data_o=0x3000000, FSM_left_right_o=0.
  - cycle 3: done_o=1, swap_o=0, exp_common_o=0x85, mant_large_o=0x2000000.
- exp_x=0x10, exp_y=0xF0 → Shift_Value_o=26 (clamped), swap_o=1, exp_common_o=0xF0, Shift_Data_o=mant_x.
- exp_x=exp_y=0x7F, mant_x=0x2000000, mant_y=0x2800000 → Shift_Value_o=0, swap_o=1. Repeat with equal mantissas → swap_o=0.
- exp diff exactly 26 and exactly 27 → Shift_Value_o=26 in both cases.
- Hold done_o 5 cycles with ack_i=0 → outputs stable, ctrl_a_o stays 0, a start_i pulse is ignored. Then ack_i=1 together with start_i=1 → IDLE next cycle with no new capture.
- rst=0 pulse asynchronous during LOAD:
  - All outputs 0 immediately, ready_o=1, ctrl_a_o drops without a completed pulse.
  - After release, a new start completes with the normal 3-cycle latency.
